// File: rtl/rcc_eth_pkg.sv
// Shared definitions for the ETH kernel clock switch sequencer:
// FSM state encoding, default wait lengths and counter width.
package rcc_eth_pkg;

    localparam int unsigned GATE_WAIT_DEF   = 4;
    localparam int unsigned SETTLE_WAIT_DEF = 48;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE_OFF = 3'd1,
        ST_SWITCH   = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_GATE_ON  = 3'd4
    } state_t;

    // States during which the kernel clock gates are held inactive.
    function automatic logic state_gates_off(input state_t st);
        return (st == ST_GATE_OFF) || (st == ST_SWITCH) || (st == ST_SETTLE);
    endfunction

endpackage

// File: rtl/rcc_eth_clk_switch_seq.sv
// ETH kernel clock source switch sequencer: gates the kernel clocks,
// waits, changes the MII/RMII and speed selects, waits for the divider
// outputs to settle, then ungates. All outputs are registered.
module rcc_eth_clk_switch_seq
    import rcc_eth_pkg::*;
#(
    parameter int unsigned GATE_WAIT   = GATE_WAIT_DEF,
    parameter int unsigned SETTLE_WAIT = SETTLE_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_epis_2,
    input  logic req_fes,
    input  logic test_mode,
    output logic sel_epis_2,
    output logic sel_fes,
    output logic gate_force_off,
    output logic busy,
    output logic switch_done
);

    // Counter reload values; the counter expires at zero, so a load of
    // N-1 yields exactly N cycles in the waiting state.
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_tgt_epis_2;
    logic               w_tgt_epis_2_next;
    logic               r_tgt_fes;
    logic               w_tgt_fes_next;
    logic               r_sel_epis_2;
    logic               w_sel_epis_2_next;
    logic               r_sel_fes;
    logic               w_sel_fes_next;
    logic               r_gate;
    logic               w_gate_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;

    // Next-state, counter and next-output decode; outputs are derived from
    // the next state so that they are valid in the same cycle as the state.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_tgt_epis_2_next = r_tgt_epis_2;
        w_tgt_fes_next    = r_tgt_fes;
        w_sel_epis_2_next = r_sel_epis_2;
        w_sel_fes_next    = r_sel_fes;
        w_done_next       = 1'b0;

        if (test_mode) begin
            // DFT bypass: selects track the requests directly, sequencer parked.
            w_state_next      = ST_IDLE;
            w_cnt_next        = '0;
            w_sel_epis_2_next = req_epis_2;
            w_sel_fes_next    = req_fes;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ({req_epis_2, req_fes} != {r_sel_epis_2, r_sel_fes}) begin
                        w_tgt_epis_2_next = req_epis_2;
                        w_tgt_fes_next    = req_fes;
                        w_cnt_next        = GATE_LOAD;
                        w_state_next      = ST_GATE_OFF;
                    end
                end
                ST_GATE_OFF: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_SWITCH;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                ST_SWITCH: begin
                    w_sel_epis_2_next = r_tgt_epis_2;
                    w_sel_fes_next    = r_tgt_fes;
                    w_cnt_next        = SETTLE_LOAD;
                    w_state_next      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_GATE_ON;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                ST_GATE_ON: begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        w_gate_next = state_gates_off(w_state_next);
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // State, counter, latched target and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tgt_epis_2 <= 1'b0;
            r_tgt_fes    <= 1'b0;
            r_sel_epis_2 <= 1'b0;
            r_sel_fes    <= 1'b0;
            r_gate       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_tgt_epis_2 <= w_tgt_epis_2_next;
            r_tgt_fes    <= w_tgt_fes_next;
            r_sel_epis_2 <= w_sel_epis_2_next;
            r_sel_fes    <= w_sel_fes_next;
            r_gate       <= w_gate_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    assign sel_epis_2     = r_sel_epis_2;
    assign sel_fes        = r_sel_fes;
    assign gate_force_off = r_gate;
    assign busy           = r_busy;
    assign switch_done    = r_done;

endmodule

// File: tb/tb_rcc_eth_clk_switch_seq.sv
// Bench for the ETH clock switch sequencer: a timestamp-based reference
// model predicts each switch sequence, a scoreboard queue holds the
// expected completions, and a monitor checks the DUT every cycle.
module tb_rcc_eth_clk_switch_seq;

    localparam int GW = 4;
    localparam int SW = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_epis_2 = 1'b0;
    logic req_fes = 1'b0;
    logic test_mode = 1'b0;
    logic sel_epis_2, sel_fes, gate_force_off, busy, switch_done;

    logic req2_epis_2 = 1'b0;
    logic req2_fes = 1'b0;
    logic tm2 = 1'b0;
    logic sel2_epis_2, sel2_fes, gate2, busy2, done2;

    always #5 clk = ~clk;

    rcc_eth_clk_switch_seq u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_epis_2     (req_epis_2),
        .req_fes        (req_fes),
        .test_mode      (test_mode),
        .sel_epis_2     (sel_epis_2),
        .sel_fes        (sel_fes),
        .gate_force_off (gate_force_off),
        .busy           (busy),
        .switch_done    (switch_done)
    );

    rcc_eth_clk_switch_seq #(.GATE_WAIT(1), .SETTLE_WAIT(1)) u_dut_fast (
        .clk            (clk),
        .rst            (rst),
        .req_epis_2     (req2_epis_2),
        .req_fes        (req2_fes),
        .test_mode      (tm2),
        .sel_epis_2     (sel2_epis_2),
        .sel_fes        (sel2_fes),
        .gate_force_off (gate2),
        .busy           (busy2),
        .switch_done    (done2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic ep;
        logic fes;
        int   done_edge;
    } exp_t;

    exp_t sb_q[$];

    int   edge_cnt = 0;
    bit   m_in_seq = 1'b0;
    int   m_start = 0;
    int   m_d = 0;
    logic m_tgt_ep = 1'b0, m_tgt_fes = 1'b0;
    logic m_app_ep = 1'b0, m_app_fes = 1'b0;
    logic m_exp_gate = 1'b0, m_exp_busy = 1'b0;
    bit   m_tm_last = 1'b0;
    bit   m_rst_mark = 1'b1;

    // A sequence started at edge s: clocks gated for edges s..s+GW+SW,
    // busy through s+GW+SW+1, selects applied at s+GW+1, done at s+GW+SW+2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_seq   = 1'b0;
            m_app_ep   = 1'b0;
            m_app_fes  = 1'b0;
            m_exp_gate = 1'b0;
            m_exp_busy = 1'b0;
            m_rst_mark = 1'b1;
            sb_q.delete();
        end else begin
            edge_cnt++;
            m_tm_last = test_mode;
            if (test_mode) begin
                m_in_seq   = 1'b0;
                m_app_ep   = req_epis_2;
                m_app_fes  = req_fes;
                m_exp_gate = 1'b0;
                m_exp_busy = 1'b0;
                sb_q.delete();
            end else if (m_in_seq) begin
                m_d = edge_cnt - m_start;
                m_exp_gate = (m_d <= GW + SW);
                m_exp_busy = (m_d <= GW + SW + 1);
                if (m_d == GW + 1) begin
                    m_app_ep  = m_tgt_ep;
                    m_app_fes = m_tgt_fes;
                end
                if (m_d == GW + SW + 2) m_in_seq = 1'b0;
            end else if ({req_epis_2, req_fes} != {m_app_ep, m_app_fes}) begin
                m_in_seq   = 1'b1;
                m_start    = edge_cnt;
                m_tgt_ep   = req_epis_2;
                m_tgt_fes  = req_fes;
                m_exp_gate = 1'b1;
                m_exp_busy = 1'b1;
                sb_q.push_back('{req_epis_2, req_fes, edge_cnt + GW + SW + 2});
            end else begin
                m_exp_gate = 1'b0;
                m_exp_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] prev_sel = 2'b00;
    logic       prev_gate = 1'b0;
    exp_t       popped;

    always @(negedge clk) begin
        chk("sel", {30'd0, sel_epis_2, sel_fes}, {30'd0, m_app_ep, m_app_fes});
        chk("gate_force_off", {31'd0, gate_force_off}, {31'd0, m_exp_gate});
        chk("busy", {31'd0, busy}, {31'd0, m_exp_busy});

        if (switch_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                popped = sb_q.pop_front();
                chk("done_edge", edge_cnt, popped.done_edge);
                chk("done_sel", {30'd0, sel_epis_2, sel_fes}, {30'd0, popped.ep, popped.fes});
            end
        end else if (sb_q.size() > 0 && sb_q[0].done_edge < edge_cnt) begin
            chk("missed_done", edge_cnt, sb_q[0].done_edge);
            popped = sb_q.pop_front();
        end

        // Selects may only move while the clock gates are forced off.
        if (!rst && !m_rst_mark && !m_tm_last && ({sel_epis_2, sel_fes} != prev_sel))
            chk("sel_change_gated", {30'd0, prev_gate, gate_force_off}, 3);

        prev_sel   = {sel_epis_2, sel_fes};
        prev_gate  = gate_force_off;
        m_rst_mark = rst;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_reset_checked(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_gate"}, {31'd0, gate_force_off}, 0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 0);
        chk({tag, "_rst_sel"}, {30'd0, sel_epis_2, sel_fes}, 0);
        chk({tag, "_rst_done"}, {31'd0, switch_done}, 0);
        #1 rst = 1'b0;
    endtask

    int  fast_n;
    bit  fast_found;
    int  r;
    int  tm_left;
    logic [1:0] saved;
    logic [1:0] rnd2;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_sel", {30'd0, sel_epis_2, sel_fes}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Minimum waits: done pulse exactly 5 cycles after the mismatch.
        req2_epis_2 = 1'b1;
        fast_n = 0;
        fast_found = 1'b0;
        for (int i = 1; i <= 20 && !fast_found; i++) begin
            @(negedge clk);
            if (i == 1) chk("fast_gate_c1", {31'd0, gate2}, 1);
            if (done2) begin
                fast_found = 1'b1;
                fast_n = i;
            end
        end
        chk("fast_done_latency", fast_n, 5);
        chk("fast_sel", {30'd0, sel2_epis_2, sel2_fes}, 2);
        chk("fast_idle", {30'd0, busy2, gate2}, 0);

        // Default waits: switch to {1,0}, done 55 cycles after the request.
        req_epis_2 = 1'b1;
        repeat (70) @(negedge clk);
        chk("seq1_sel", {30'd0, sel_epis_2, sel_fes}, 2);

        // Speed request toggles back while settling: two sequences, ends fes=0.
        req_fes = 1'b1;
        repeat (25) @(negedge clk);
        req_fes = 1'b0;
        repeat (130) @(negedge clk);
        chk("toggle_final_sel", {30'd0, sel_epis_2, sel_fes}, 2);

        // Reset during GATE_OFF, mismatch persists afterwards -> fresh sequence.
        req_epis_2 = 1'b0;
        req_fes = 1'b1;
        repeat (3) @(negedge clk);
        pulse_reset_checked("gateoff");
        repeat (70) @(negedge clk);
        chk("after_rst_sel", {30'd0, sel_epis_2, sel_fes}, 1);

        // DFT bypass: selects follow next cycle, no gating, no done.
        test_mode = 1'b1;
        @(negedge clk);
        req_epis_2 = 1'b1;
        req_fes = 1'b0;
        @(negedge clk);
        chk("tm_sel_follow", {30'd0, sel_epis_2, sel_fes}, 2);
        chk("tm_quiet", {29'd0, busy, gate_force_off, switch_done}, 0);
        repeat (3) @(negedge clk);
        test_mode = 1'b0;
        repeat (5) @(negedge clk);

        // Randomized traffic.
        tm_left = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (tm_left > 0) begin
                tm_left--;
                if (tm_left == 0) test_mode = 1'b0;
            end
            r = $urandom_range(0, 999);
            if (r < 15) begin
                rnd2 = 2'($urandom_range(0, 3));
                req_epis_2 = rnd2[1];
                req_fes = rnd2[0];
            end else if (r < 18 && tm_left == 0) begin
                test_mode = 1'b1;
                tm_left = $urandom_range(1, 4);
            end else if (r < 21) begin
                saved = {req_epis_2, req_fes};
                {req_epis_2, req_fes} = ~saved;
                #2 {req_epis_2, req_fes} = saved;
            end else if (r == 21) begin
                pulse_reset_checked("rand");
            end
        end

        test_mode = 1'b0;
        for (int i = 0; i < 200 && (sb_q.size() != 0 || busy); i++) @(negedge clk);
        chk("drain_pending", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
